// File: rtl/common.sv
// Shared definitions for the PSG bus master.
//   psg_state_t : bus-master FSM states
//   PSG_*       : {bdir, bc1} bus-mode encodings
//   psg_bus_t   : one registered snapshot of the external PSG bus pins
//   phase_len   : maps a phase-length parameter to the 3-bit counter load value
//   bus_drive   : bus pin values that belong to a given state
package common;

  typedef enum logic [2:0] {
    IDLE, SEL_LATCH, SEL_GAP, ADDR, ADDR_GAP, WRITE, READ, GAP
  } psg_state_t;

  localparam logic [1:0] PSG_INACT = 2'b00;
  localparam logic [1:0] PSG_LATCH = 2'b11;
  localparam logic [1:0] PSG_WRITE = 2'b10;
  localparam logic [1:0] PSG_READ  = 2'b01;

  typedef struct packed {
    logic       bdir;
    logic       bc1;
    logic       da_oe;
    logic [7:0] da_out;
  } psg_bus_t;

  // A length of 0 behaves as 1; the counter is 3 bits, so cap at 7.
  function automatic logic [2:0] phase_len(input int p);
    if (p < 1) return 3'd1;
    if (p > 7) return 3'd7;
    return p[2:0];
  endfunction

  // The data bus is only driven while bdir=1, and reads as 0 otherwise.
  function automatic psg_bus_t bus_drive(input psg_state_t s, input logic chip,
                                         input logic [3:0] addr, input logic [7:0] data);
    psg_bus_t   b;
    logic [1:0] mode;
    logic [7:0] val;
    mode = PSG_INACT;
    val  = 8'h00;
    case (s)
      SEL_LATCH: begin mode = PSG_LATCH; val = chip ? 8'hFE : 8'hFF; end
      ADDR:      begin mode = PSG_LATCH; val = {4'h0, addr};         end
      WRITE:     begin mode = PSG_WRITE; val = data;                 end
      READ:      begin mode = PSG_READ;                              end
      default:   ;
    endcase
    b.bdir   = mode[1];
    b.bc1    = mode[0];
    b.da_oe  = mode[1];
    b.da_out = mode[1] ? val : 8'h00;
    return b;
  endfunction

endpackage

// File: rtl/psg_phase_timer.sv
// Phase timer for the PSG bus master.
//   clk28 : system clock          rst  : synchronous active-high reset
//   load  : first cycle of a phase; loads n, ignores any ck35 in that cycle
//   n     : phase length in ck35 ticks (1..7)
//   ck35  : 3.5 MHz enable pulse  done : this cycle carries the phase's last tick
module psg_phase_timer (
  input  logic       clk28,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] n,
  input  logic       ck35,
  output logic       done
);

  logic [2:0] cnt;

  // Counts down to 1 and parks there; the FSM reloads it on the next entry.
  always_ff @(posedge clk28) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= n;
    end else if (ck35 && (cnt > 3'd1)) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign done = !load && ck35 && (cnt == 3'd1);

endmodule

// File: rtl/psg_bus_master.sv
// Sequences AY/YM PSG register reads and writes on the external bus, with
// TurboSound chip selection (select latch of 8'hFF / 8'hFE).
//   clk28, rst           : clock and synchronous active-high reset
//   ck35                 : one-cycle 3.5 MHz enable that paces every bus phase
//   en_ts                : TurboSound enable; when low the request targets chip 0
//   req_*                : request channel (valid/ready)
//   rsp_valid, rsp_data  : read response pulse and held read data
//   psg_bdir, psg_bc1    : registered bus mode
//   psg_da_out/oe/in     : external data bus
//   dbg_state            : current FSM state
//
// Handshake: a request transfers on a clock edge where req_valid=1 and
// req_ready=1. req_ready is high only while idle and does not depend on
// req_valid; the requester holds its fields stable while req_valid=1 and
// the transfer has not happened.
module psg_bus_master
  import common::*;
#(
  parameter int T_ADDR = 1,
  parameter int T_WR   = 2,
  parameter int T_RD   = 2,
  parameter int T_GAP  = 1
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ck35,
  input  logic       en_ts,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic       req_chip,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       psg_bdir,
  output logic       psg_bc1,
  output logic [7:0] psg_da_out,
  output logic       psg_da_oe,
  input  logic [7:0] psg_da_in,
  output psg_state_t dbg_state
);

  localparam logic [2:0] N_ADDR = phase_len(T_ADDR);
  localparam logic [2:0] N_WR   = phase_len(T_WR);
  localparam logic [2:0] N_RD   = phase_len(T_RD);
  localparam logic [2:0] N_GAP  = phase_len(T_GAP);

  psg_state_t state, state_nxt;
  psg_bus_t   bus_nxt;
  logic       accept, eff_chip;
  logic       wr_q, chip_q, chip_nxt;
  logic [3:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;
  logic       cur_chip, sel_known;
  logic       phase_load, phase_done;
  logic [2:0] phase_n;

  assign accept    = req_valid && req_ready;
  assign eff_chip  = req_chip & en_ts;
  assign dbg_state = state;

  // Values the transaction will carry after this edge, so the bus registers
  // can be loaded in the same edge that enters the new state.
  assign chip_nxt = accept ? eff_chip : chip_q;
  assign addr_nxt = accept ? req_addr : addr_q;
  assign data_nxt = accept ? req_data : data_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = (!sel_known || (eff_chip != cur_chip)) ? SEL_LATCH : ADDR;
      SEL_LATCH: if (phase_done) state_nxt = SEL_GAP;
      SEL_GAP:   if (phase_done) state_nxt = ADDR;
      ADDR:      if (phase_done) state_nxt = ADDR_GAP;
      ADDR_GAP:  if (phase_done) state_nxt = wr_q ? WRITE : READ;
      WRITE:     if (phase_done) state_nxt = GAP;
      READ:      if (phase_done) state_nxt = GAP;
      GAP:       if (phase_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    phase_n = 3'd1;
    case (state)
      SEL_LATCH, ADDR:          phase_n = N_ADDR;
      WRITE:                    phase_n = N_WR;
      READ:                     phase_n = N_RD;
      SEL_GAP, ADDR_GAP, GAP:   phase_n = N_GAP;
      default:                  phase_n = 3'd1;
    endcase
  end

  assign bus_nxt = bus_drive(state_nxt, chip_nxt, addr_nxt, data_nxt);

  psg_phase_timer u_timer (
    .clk28 (clk28),
    .rst   (rst),
    .load  (phase_load),
    .n     (phase_n),
    .ck35  (ck35),
    .done  (phase_done)
  );

  always_ff @(posedge clk28) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      psg_bdir   <= 1'b0;
      psg_bc1    <= 1'b0;
      psg_da_out <= 8'h00;
      psg_da_oe  <= 1'b0;
      cur_chip   <= 1'b0;
      sel_known  <= 1'b0;
      phase_load <= 1'b0;
      wr_q       <= 1'b0;
      chip_q     <= 1'b0;
      addr_q     <= 4'h0;
      data_q     <= 8'h00;
    end else begin
      state      <= state_nxt;
      // The timer loads during the first cycle of every new state, which is
      // also what makes a ck35 in that entry cycle not count.
      phase_load <= (state_nxt != state);
      req_ready  <= (state_nxt == IDLE);
      psg_bdir   <= bus_nxt.bdir;
      psg_bc1    <= bus_nxt.bc1;
      psg_da_out <= bus_nxt.da_out;
      psg_da_oe  <= bus_nxt.da_oe;
      rsp_valid  <= (state == READ) && phase_done;
      if (accept) begin
        wr_q   <= req_wr;
        chip_q <= eff_chip;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if ((state == SEL_LATCH) && phase_done) begin
        cur_chip  <= chip_q;
        sel_known <= 1'b1;
      end
      if ((state == READ) && phase_done) begin
        rsp_data <= psg_da_in;
      end
    end
  end

endmodule

// File: tb/tb_psg_bus_master.sv
module tb_psg_bus_master;
  import common::*;

  localparam int TA = 1, TW = 2, TR = 2, TG = 1;
  localparam logic [1:0] K_NONE = 2'd0, K_SEL = 2'd1, K_READ = 2'd2;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] dout;
    logic [3:0] len;
    logic [1:0] kind;
    logic       chip;
  } phase_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk28 = 1'b0;
  logic rst = 1'b1;
  logic ck35 = 1'b0;
  logic en_ts = 1'b1;
  logic req_valid = 1'b0, req_wr = 1'b0, req_chip = 1'b0;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_data = 8'h00, psg_da_in = 8'h00;
  logic req_ready, rsp_valid, psg_bdir, psg_bc1, psg_da_oe;
  logic [7:0] rsp_data, psg_da_out;
  psg_state_t dbg_state;

  always #5 clk28 = ~clk28;

  psg_bus_master #(.T_ADDR(TA), .T_WR(TW), .T_RD(TR), .T_GAP(TG)) dut (
    .clk28(clk28), .rst(rst), .ck35(ck35), .en_ts(en_ts),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_chip(req_chip), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .psg_bdir(psg_bdir), .psg_bc1(psg_bc1), .psg_da_out(psg_da_out),
    .psg_da_oe(psg_da_oe), .psg_da_in(psg_da_in), .dbg_state(dbg_state)
  );

  // ck35: one pulse every 8 clk28 cycles, changed on the falling edge.
  int ck_cnt = 0;
  always @(negedge clk28) begin
    ck_cnt = (ck_cnt + 1) % 8;
    ck35   = (ck_cnt == 0);
  end

  // ---------------- scoring ----------------
  int n_run = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction is a list of bus phases; each phase holds its pins until it
  // has seen 'len' ck35 pulses, not counting a pulse in its first cycle.
  phase_t ph_q[$];
  phase_t m_ph;
  bit     m_busy = 0, m_fresh = 0, m_cur_chip = 0, m_sel_known = 0, m_eff;
  int     m_seen = 0;
  logic       ex_bdir = 0, ex_bc1 = 0, ex_oe = 0, ex_ready = 0, ex_rsp_valid = 0;
  logic [7:0] ex_out = 0, ex_rsp_data = 0;

  function automatic logic [3:0] plen(input int p);
    return (p < 1) ? 4'd1 : 4'(p);
  endfunction

  task automatic add_ph(input logic [1:0] mode, input logic [7:0] d, input logic [3:0] len,
                        input logic [1:0] kind, input logic chip);
    phase_t p;
    p = '{mode, d, len, kind, chip};
    ph_q.push_back(p);
  endtask

  task automatic start_next();
    m_ph    = ph_q.pop_front();
    m_seen  = 0;
    m_fresh = 1;
    m_busy  = 1;
    ex_bdir = m_ph.mode[1];
    ex_bc1  = m_ph.mode[0];
    ex_oe   = m_ph.mode[1];
    ex_out  = m_ph.mode[1] ? m_ph.dout : 8'h00;
  endtask

  always @(posedge clk28) begin
    if (rst) begin
      ph_q.delete();
      m_busy = 0; m_fresh = 0; m_cur_chip = 0; m_sel_known = 0;
      ex_bdir = 0; ex_bc1 = 0; ex_oe = 0; ex_out = 0;
      ex_ready = 0; ex_rsp_valid = 0; ex_rsp_data = 0;
    end else begin
      ex_rsp_valid = 0;
      if (!m_busy) begin
        if (ex_ready && req_valid) begin
          m_eff = req_chip & en_ts;
          if (!m_sel_known || (m_eff != m_cur_chip)) begin
            add_ph(2'b11, m_eff ? 8'hFE : 8'hFF, plen(TA), K_SEL, m_eff);
            add_ph(2'b00, 8'h00, plen(TG), K_NONE, 1'b0);
          end
          add_ph(2'b11, {4'h0, req_addr}, plen(TA), K_NONE, 1'b0);
          add_ph(2'b00, 8'h00, plen(TG), K_NONE, 1'b0);
          if (req_wr) add_ph(2'b10, req_data, plen(TW), K_NONE, 1'b0);
          else        add_ph(2'b01, 8'h00, plen(TR), K_READ, 1'b0);
          add_ph(2'b00, 8'h00, plen(TG), K_NONE, 1'b0);
          ex_ready = 0;
          start_next();
        end else begin
          ex_ready = 1;
        end
      end else if (m_fresh) begin
        m_fresh = 0;
      end else if (ck35) begin
        m_seen++;
        if (m_seen == int'(m_ph.len)) begin
          if (m_ph.kind == K_SEL) begin
            m_cur_chip  = m_ph.chip;
            m_sel_known = 1;
          end
          if (m_ph.kind == K_READ) begin
            ex_rsp_valid = 1;
            ex_rsp_data  = psg_da_in;
          end
          if (ph_q.size() == 0) begin
            m_busy = 0;
            ex_bdir = 0; ex_bc1 = 0; ex_oe = 0; ex_out = 0;
            ex_ready = 1;
          end else begin
            start_next();
          end
        end
      end
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk28) begin
    if (chk_en)
      check("cycle", {11'h0, psg_bdir, psg_bc1, psg_da_oe, psg_da_out, req_ready, rsp_valid, rsp_data},
                     {11'h0, ex_bdir, ex_bc1, ex_oe, ex_out, ex_ready, ex_rsp_valid, ex_rsp_data});
  end

  // ---------------- bus segment logger ----------------
  logic [10:0] seg_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] last_seg = 11'h0;
  int rsp_cnt = 0, addr9_cycles = 0;

  function automatic logic [10:0] seg(input logic [1:0] mode, input logic oe, input logic [7:0] d);
    return {mode, oe, d};
  endfunction

  always @(negedge clk28) begin
    if (chk_en) begin
      if ({psg_bdir, psg_bc1, psg_da_oe, psg_da_out} != last_seg) begin
        last_seg = {psg_bdir, psg_bc1, psg_da_oe, psg_da_out};
        seg_q.push_back(last_seg);
      end
      if (rsp_valid) rsp_cnt++;
      if ({psg_bdir, psg_bc1} == 2'b11 && psg_da_out == 8'h09) addr9_cycles++;
    end
  end

  task automatic compare_segs(input string name);
    check({name, "_len"}, seg_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seg_q.size(); i++)
      check($sformatf("%s_%0d", name, i), {21'h0, seg_q[i]}, {21'h0, exp_q[i]});
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 400) begin
      @(negedge clk28); #1;
      guard++;
    end
    if (guard >= 400) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_txn(input string name, input logic wr, input logic chip, input logic ets,
                        input logic [3:0] addr, input logic [7:0] data, input bit align);
    wait_ready(name);
    if (align) begin
      for (int g = 0; g < 20 && ck_cnt != 7; g++) begin
        @(negedge clk28); #1;
      end
    end
    seg_q.delete();
    req_wr = wr; req_chip = chip; en_ts = ets; req_addr = addr; req_data = data;
    req_valid = 1;
    @(posedge clk28); #1;
    req_valid = 0;
    @(negedge clk28); #1;
    wait_ready(name);
  endtask

  // ---------------- directed sequence ----------------
  int rsp_before;

  initial begin
    repeat (3) @(posedge clk28);
    chk_en = 1;
    @(negedge clk28);
    check("reset_outputs", {psg_bdir, psg_bc1, psg_da_oe, psg_da_out, req_ready, rsp_valid, rsp_data}, 0);
    rst = 0;
    @(negedge clk28);
    check("ready_after_reset", req_ready, 1);

    // Write chip0 reg 7 = 38: select FF, address 07, data 38.
    do_txn("w_c0_r7", 1, 0, 1, 4'd7, 8'h38, 0);
    exp_q = '{seg(2'b11,1,8'hFF), seg(2'b00,0,8'h00), seg(2'b11,1,8'h07), seg(2'b00,0,8'h00),
              seg(2'b10,1,8'h38), seg(2'b00,0,8'h00)};
    compare_segs("w_c0_r7");

    // Same chip again: no select cycle.
    do_txn("w_c0_r8", 1, 0, 1, 4'd8, 8'h0F, 0);
    exp_q = '{seg(2'b11,1,8'h08), seg(2'b00,0,8'h00), seg(2'b10,1,8'h0F), seg(2'b00,0,8'h00)};
    compare_segs("w_c0_r8");

    // Read chip1 reg 14: select FE, bus released during READ.
    psg_da_in = 8'hA5;
    rsp_before = rsp_cnt;
    do_txn("r_c1_r14", 0, 1, 1, 4'd14, 8'h00, 0);
    exp_q = '{seg(2'b11,1,8'hFE), seg(2'b00,0,8'h00), seg(2'b11,1,8'h0E), seg(2'b00,0,8'h00),
              seg(2'b01,0,8'h00), seg(2'b00,0,8'h00)};
    compare_segs("r_c1_r14");
    check("r_c1_rsp_count", rsp_cnt - rsp_before, 1);
    check("r_c1_rsp_data", rsp_data, 8'hA5);

    // Back to chip0: select FF again.
    do_txn("w_c0_r2", 1, 0, 1, 4'd2, 8'h55, 0);
    exp_q = '{seg(2'b11,1,8'hFF), seg(2'b00,0,8'h00), seg(2'b11,1,8'h02), seg(2'b00,0,8'h00),
              seg(2'b10,1,8'h55), seg(2'b00,0,8'h00)};
    compare_segs("w_c0_r2");

    // Chip1 requested with TurboSound off: lands on chip0, no select.
    psg_da_in = 8'h3C;
    rsp_before = rsp_cnt;
    do_txn("r_ts_off", 0, 1, 0, 4'd3, 8'h00, 0);
    exp_q = '{seg(2'b11,1,8'h03), seg(2'b00,0,8'h00), seg(2'b01,0,8'h00), seg(2'b00,0,8'h00)};
    compare_segs("r_ts_off");
    check("r_ts_off_rsp_count", rsp_cnt - rsp_before, 1);
    check("r_ts_off_rsp_data", rsp_data, 8'h3C);

    // ck35 lands in the ADDR entry cycle: that pulse is ignored, so ADDR
    // lasts through the next pulse 8 cycles later (9 cycles in total).
    addr9_cycles = 0;
    do_txn("w_align", 1, 0, 1, 4'd9, 8'hAA, 1);
    check("addr_entry_pulse_cycles", addr9_cycles, 9);
    exp_q = '{seg(2'b11,1,8'h09), seg(2'b00,0,8'h00), seg(2'b10,1,8'hAA), seg(2'b00,0,8'h00)};
    compare_segs("w_align");

    // req_valid held across three writes: one accept each.
    wait_ready("burst");
    seg_q.delete();
    en_ts = 1; req_wr = 1; req_chip = 0;
    req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      wait_ready("burst");
      req_addr = 4'(10 + k);
      req_data = 8'(8'h60 + k);
      @(posedge clk28); #1;
    end
    req_valid = 0;
    @(negedge clk28); #1;
    wait_ready("burst_end");
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(seg(2'b11, 1, 8'(10 + k)));
      exp_q.push_back(seg(2'b00, 0, 8'h00));
      exp_q.push_back(seg(2'b10, 1, 8'(8'h60 + k)));
      exp_q.push_back(seg(2'b00, 0, 8'h00));
    end
    compare_segs("burst");

    // Reset in the middle of a WRITE aborts it and forgets the selected chip.
    rsp_before = rsp_cnt;
    req_wr = 1; req_chip = 0; en_ts = 1; req_addr = 4'd5; req_data = 8'h77;
    req_valid = 1;
    @(posedge clk28); #1;
    req_valid = 0;
    for (int g = 0; g < 200 && !(psg_bdir === 1'b1 && psg_bc1 === 1'b0); g++) begin
      @(negedge clk28); #1;
    end
    check("abort_reached_write", {psg_bdir, psg_bc1}, 2'b10);
    rst = 1;
    @(negedge clk28);
    check("abort_bus_idle", {psg_bdir, psg_bc1, psg_da_oe, psg_da_out}, 0);
    check("abort_no_rsp", rsp_valid, 0);
    @(negedge clk28);
    rst = 0;
    do_txn("after_abort", 1, 0, 1, 4'd7, 8'h11, 0);
    exp_q = '{seg(2'b11,1,8'hFF), seg(2'b00,0,8'h00), seg(2'b11,1,8'h07), seg(2'b00,0,8'h00),
              seg(2'b10,1,8'h11), seg(2'b00,0,8'h00)};
    compare_segs("after_abort");
    check("abort_rsp_count", rsp_cnt - rsp_before, 0);

    repeat (4) @(negedge clk28);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
